// File: rtl/axis_width_downsizer.sv
// AXI4-Stream width downsizer: one wide slave beat is held and
// replayed as RATIO narrow master beats, lowest bytes first.
//
// Parameters:
//   IN_WIDTH  - slave tdata width in bits, rounded up to whole bytes
//   OUT_WIDTH - master tdata width in bits, rounded up to whole bytes
// Ports:
//   aclk, aresetn            - clock, async active-low reset
//   s_tvalid/s_tready        - slave handshake
//   s_tdata/s_tkeep/s_tlast  - slave beat (IN_BYTES wide)
//   m_tvalid/m_tready        - master handshake
//   m_tdata/m_tkeep/m_tlast  - master chunk (OUT_BYTES wide)
// Build option:
//   AXIS_DWN_NULL_SKIP_EN - chunks with an all-zero tkeep slice are
//   not emitted; a fully null, non-last beat is swallowed.
module axis_width_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    localparam int IN_BYTES  = (IN_WIDTH - 1) / 8 + 1,
    localparam int OUT_BYTES = (OUT_WIDTH - 1) / 8 + 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [IN_BYTES*8-1:0]  s_tdata,
    input  logic [IN_BYTES-1:0]    s_tkeep,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [OUT_BYTES*8-1:0] m_tdata,
    output logic [OUT_BYTES-1:0]   m_tkeep,
    output logic                   m_tlast
);

    localparam int RATIO = IN_BYTES / OUT_BYTES;
    localparam int OW    = OUT_BYTES * 8;
    localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((IN_BYTES % OUT_BYTES) != 0 || RATIO < 1) begin : g_bad_ratio
        $error("axis_width_downsizer: IN_BYTES must be a multiple of OUT_BYTES");
    end

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [IN_BYTES*8-1:0] r_data;
    logic [IN_BYTES-1:0]   r_keep;
    logic                  r_last;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_fin;
    logic                  r_rdy;

    state_t                w_nstate;
    logic [IN_BYTES*8-1:0] w_data;
    logic [IN_BYTES-1:0]   w_keep;
    logic                  w_last;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_fin;
    logic                  w_load;

    logic                  w_final;
    logic                  w_s_fire;
    logic [IW-1:0]         w_first;
    logic [IW-1:0]         w_fin_in;
    logic [IW-1:0]         w_nxt_idx;
    logic                  w_drop;

    logic [OW-1:0]         w_dchunk [RATIO];
    logic [OUT_BYTES-1:0]  w_kchunk [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_chunk
        assign w_dchunk[g] = r_data[g*OW +: OW];
        assign w_kchunk[g] = r_keep[g*OUT_BYTES +: OUT_BYTES];
    end

`ifdef AXIS_DWN_NULL_SKIP_EN
    function automatic logic f_nz(
        input logic [IN_BYTES-1:0] k,
        input int                  i
    );
        f_nz = |k[i*OUT_BYTES +: OUT_BYTES];
    endfunction

    // Lowest non-null chunk; 0 for an all-null beat.
    function automatic logic [IW-1:0] f_first(
        input logic [IN_BYTES-1:0] k
    );
        f_first = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (f_nz(k, i)) f_first = IW'(i);
        end
    endfunction

    // Highest non-null chunk; 0 for an all-null beat.
    function automatic logic [IW-1:0] f_lastnz(
        input logic [IN_BYTES-1:0] k
    );
        f_lastnz = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (f_nz(k, i)) f_lastnz = IW'(i);
        end
    endfunction

    // Next non-null chunk above cur; only used when cur is not final.
    function automatic logic [IW-1:0] f_next(
        input logic [IN_BYTES-1:0] k,
        input logic [IW-1:0]       cur
    );
        logic found;
        found  = 1'b0;
        f_next = cur;
        for (int i = 0; i < RATIO; i++) begin
            if (!found && i > int'(cur) && f_nz(k, i)) begin
                f_next = IW'(i);
                found  = 1'b1;
            end
        end
    endfunction

    assign w_first   = f_first(s_tkeep);
    assign w_fin_in  = f_lastnz(s_tkeep);
    assign w_nxt_idx = f_next(r_keep, r_idx);
    assign w_drop    = ~|s_tkeep & ~s_tlast;
`else
    assign w_first   = '0;
    assign w_fin_in  = IW'(RATIO - 1);
    assign w_nxt_idx = r_idx + IW'(1);
    assign w_drop    = 1'b0;
`endif

    assign w_final  = (r_idx == r_fin);
    assign m_tvalid = (r_state == S_HOLD);

    // Ready opens in the final-chunk cycle so a new beat can be taken
    // without a bubble between packets.
    assign s_tready = r_rdy &
                      ((r_state == S_EMPTY) | (m_tready & w_final));
    assign w_s_fire = s_tvalid & s_tready;

    assign m_tdata = m_tvalid ? w_dchunk[r_idx] : '0;
    assign m_tkeep = m_tvalid ? w_kchunk[r_idx] : '0;
    assign m_tlast = m_tvalid & r_last & w_final;

    always_comb begin
        w_nstate = r_state;
        w_data   = r_data;
        w_keep   = r_keep;
        w_last   = r_last;
        w_idx    = r_idx;
        w_fin    = r_fin;
        w_load   = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (w_s_fire) w_load = 1'b1;
            end
            S_HOLD: begin
                if (m_tready) begin
                    if (w_final) begin
                        if (w_s_fire) w_load = 1'b1;
                        else          w_nstate = S_EMPTY;
                    end else begin
                        w_idx = w_nxt_idx;
                    end
                end
            end
            default: w_nstate = S_EMPTY;
        endcase
        if (w_load) begin
            w_data   = s_tdata;
            w_keep   = s_tkeep;
            w_last   = s_tlast;
            w_idx    = w_first;
            w_fin    = w_fin_in;
            // A fully null non-last beat carries nothing to emit.
            w_nstate = w_drop ? S_EMPTY : S_HOLD;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_fin   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_data  <= w_data;
            r_keep  <= w_keep;
            r_last  <= w_last;
            r_idx   <= w_idx;
            r_fin   <= w_fin;
            r_rdy   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed bench for axis_width_downsizer at the 32->8 default.
// Captures every master transfer and compares against fixed vectors.
module tb_axis_width_downsizer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tlast;

    axis_width_downsizer dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic       l;
        logic       sr;
        int         c;
    } beat_t;

    beat_t cap[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;

    logic       rdy = 1'b1;
    logic       pat_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         pi = 0;

    logic       p_stall = 1'b0;
    logic [7:0] p_d;
    logic       p_k;
    logic       p_l;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        if (pat_en) begin
            m_tready = pat[pi];
            pi = (pi + 1) % 4;
        end else begin
            m_tready = rdy;
        end
    end

    always @(negedge aclk) begin
        if (aresetn && p_stall) begin
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_data", m_tdata, p_d);
            chk("stall_keep", m_tkeep, p_k);
            chk("stall_last", m_tlast, p_l);
        end
        p_stall = aresetn && m_tvalid && !m_tready;
        p_d = m_tdata;
        p_k = m_tkeep;
        p_l = m_tlast;
        if (aresetn && m_tvalid && m_tready)
            cap.push_back('{m_tdata, m_tkeep, m_tlast, s_tready, cyc});
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        @(negedge aclk);
        while (!s_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("s_accept", s_tready, 1'b1);
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int i,
                            input logic [7:0] d, input logic k,
                            input logic l);
        if (i < cap.size()) begin
            chk({tag, "_d"}, cap[i].d, d);
            chk({tag, "_k"}, cap[i].k, k);
            chk({tag, "_l"}, cap[i].l, l);
        end else begin
            chk({tag, "_missing"}, cap.size(), i + 1);
        end
    endtask

    task automatic chk_nogap(input string tag);
        for (int i = 1; i < cap.size(); i++)
            chk(tag, cap[i].c - cap[i-1].c, 1);
    endtask

    initial begin
        #12;
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_sready", s_tready, 1'b0);
        chk("rst_mdata", m_tdata, 8'h00);
        chk("rst_mkeep", m_tkeep, 1'b0);
        chk("rst_mlast", m_tlast, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_sready_up", s_tready, 1'b1);

        // 1: single beat, four chunks
        cap.delete();
        send_beat(32'h44332211, 4'hF, 1'b1);
        idle(10);
        chk("t1_n", cap.size(), 4);
        chk_beat("t1_0", 0, 8'h11, 1'b1, 1'b0);
        chk_beat("t1_1", 1, 8'h22, 1'b1, 1'b0);
        chk_beat("t1_2", 2, 8'h33, 1'b1, 1'b0);
        chk_beat("t1_3", 3, 8'h44, 1'b1, 1'b1);
        chk_nogap("t1_gap");

        // 2: back-to-back beats
        cap.delete();
        send_beat(32'hDDCCBBAA, 4'hF, 1'b1);
        send_beat(32'h04030201, 4'hF, 1'b1);
        idle(12);
        chk("t2_n", cap.size(), 8);
        chk_beat("t2_0", 0, 8'hAA, 1'b1, 1'b0);
        chk_beat("t2_3", 3, 8'hDD, 1'b1, 1'b1);
        chk_beat("t2_4", 4, 8'h01, 1'b1, 1'b0);
        chk_beat("t2_7", 7, 8'h04, 1'b1, 1'b1);
        if (cap.size() == 8) begin
            chk("t2_sr_cc", cap[2].sr, 1'b0);
            chk("t2_sr_dd", cap[3].sr, 1'b1);
        end
        chk_nogap("t2_gap");

        // 3: stalled master
        cap.delete();
        pi = 0;
        pat_en = 1'b1;
        send_beat(32'h87654321, 4'hF, 1'b0);
        idle(20);
        pat_en = 1'b0;
        idle(2);
        chk("t3_n", cap.size(), 4);
        chk_beat("t3_0", 0, 8'h21, 1'b1, 1'b0);
        chk_beat("t3_1", 1, 8'h43, 1'b1, 1'b0);
        chk_beat("t3_2", 2, 8'h65, 1'b1, 1'b0);
        chk_beat("t3_3", 3, 8'h87, 1'b1, 1'b0);

        // 4: partial keep
        cap.delete();
        send_beat(32'h0000BEEF, 4'h3, 1'b1);
        idle(10);
`ifdef AXIS_DWN_NULL_SKIP_EN
        chk("t4_n", cap.size(), 2);
        chk_beat("t4_0", 0, 8'hEF, 1'b1, 1'b0);
        chk_beat("t4_1", 1, 8'hBE, 1'b1, 1'b1);
`else
        chk("t4_n", cap.size(), 4);
        chk_beat("t4_0", 0, 8'hEF, 1'b1, 1'b0);
        chk_beat("t4_1", 1, 8'hBE, 1'b1, 1'b0);
        chk_beat("t4_2", 2, 8'h00, 1'b0, 1'b0);
        chk_beat("t4_3", 3, 8'h00, 1'b0, 1'b1);
`endif

`ifdef AXIS_DWN_NULL_SKIP_EN
        // 5: fully null beats
        cap.delete();
        send_beat(32'hA5A5A5A5, 4'h0, 1'b0);
        idle(5);
        chk("t5_none", cap.size(), 0);
        send_beat(32'h000000C3, 4'h0, 1'b1);
        idle(6);
        chk("t5_n", cap.size(), 1);
        chk_beat("t5_0", 0, 8'hC3, 1'b0, 1'b1);
`endif

        // 6: reset mid-beat
        cap.delete();
        send_beat(32'h11223344, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        for (int n = 0; n < 20 && cap.size() < 2; n++) begin
            @(negedge aclk);
            #1;
        end
        chk("t6_pre_n", cap.size(), 2);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("t6_mvalid", m_tvalid, 1'b0);
        chk("t6_sready", s_tready, 1'b0);
        cap.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(4);
        chk("t6_no_partial", cap.size(), 0);
        send_beat(32'h0D0C0B0A, 4'hF, 1'b1);
        idle(10);
        chk("t6_n", cap.size(), 4);
        chk_beat("t6_0", 0, 8'h0A, 1'b1, 1'b0);
        chk_beat("t6_3", 3, 8'h0D, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
